dlatch_write_ctrl: RTL

//  Clocked write sequencer that sits directly upstream of a level-sensitive D latch (dlatch).

---
 rtl/dlatch_write_ctrl_pkg.sv | 26 ++
 rtl/dlatch_write_ctrl_if.sv | 17 +
 rtl/dlatch_write_ctrl_dly_cnt.sv | 27 ++
 rtl/dlatch_write_ctrl.sv | 124 ++++++++++++
 4 files changed

// File: rtl/dlatch_write_ctrl_pkg.sv
// Shared timing defaults, FSM encodings and counter sizing for the latch write sequencer.
package dlatch_write_ctrl_pkg;

  localparam int unsigned DEF_W     = 1;
  localparam int unsigned DEF_SETUP = 2;
  localparam int unsigned DEF_PULSE = 2;
  localparam int unsigned DEF_HOLD  = 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_PULSE = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  // Counter must hold max(SETUP,PULSE,HOLD)-1; floor of 2 keeps it at least one bit.
  function automatic int unsigned cnt_width(input int unsigned setup,
                                            input int unsigned pulse,
                                            input int unsigned hold);
    int unsigned m;
    m = 2;
    if (setup > m) m = setup;
    if (pulse > m) m = pulse;
    if (hold > m)  m = hold;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/dlatch_write_ctrl_if.sv
// Write request / latch pin bundle between upstream logic, the sequencer and the latch.
interface dlatch_write_ctrl_if #(
  parameter int unsigned W = 1
);
  logic         req;
  logic [W-1:0] din;
  logic         rdy;
  logic [W-1:0] D;
  logic         E;
  logic [W-1:0] Q;
  logic         done;
  logic         err;

  // master: upstream requester plus the latch read-back path
  modport master (output req, din, Q, input rdy, D, E, done, err);
  modport slave  (input req, din, Q, output rdy, D, E, done, err);
endinterface

// File: rtl/dlatch_write_ctrl_dly_cnt.sv
// Loadable down counter with zero flag, reused for the setup, pulse and hold phases.
module dlatch_write_ctrl_dly_cnt #(
  parameter int unsigned CW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          dec,
  input  logic [CW-1:0] load_val,
  output logic          zero_c
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/dlatch_write_ctrl.sv
// Clocked write sequencer driving a level-sensitive latch with setup / enable pulse / hold
// timing, then reading Q back and flagging a mismatch alongside a one-cycle done pulse.
module dlatch_write_ctrl
  import dlatch_write_ctrl_pkg::*;
#(
  parameter int unsigned W     = DEF_W,
  parameter int unsigned SETUP = DEF_SETUP,
  parameter int unsigned PULSE = DEF_PULSE,
  parameter int unsigned HOLD  = DEF_HOLD
) (
  input logic               clk,
  input logic               rst,
  dlatch_write_ctrl_if.slave bus
);

  localparam int unsigned CW = cnt_width(SETUP, PULSE, HOLD);

  logic [1:0]    state, state_nxt;
  logic [W-1:0]  d_q, d_nxt;
  logic          e_q, e_nxt;
  logic          done_q, done_nxt;
  logic          err_q, err_nxt;
  logic          cnt_load, cnt_dec, cnt_zero_c;
  logic [CW-1:0] cnt_val;

  dlatch_write_ctrl_dly_cnt #(.CW(CW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_val),
    .zero_c   (cnt_zero_c)
  );

  // Next state and next register values; a compare with unknown Q falls to the error branch.
  always_comb begin
    state_nxt = state;
    d_nxt     = d_q;
    e_nxt     = e_q;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_val   = '0;
    case (state)
      S_IDLE: begin
        e_nxt = 1'b0;
        if (bus.req) begin
          d_nxt     = bus.din;
          cnt_load  = 1'b1;
          cnt_val   = CW'(SETUP - 1);
          state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        e_nxt = 1'b0;
        if (cnt_zero_c) begin
          e_nxt     = 1'b1;
          cnt_load  = 1'b1;
          cnt_val   = CW'(PULSE - 1);
          state_nxt = S_PULSE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_PULSE: begin
        e_nxt = 1'b1;
        if (cnt_zero_c) begin
          e_nxt = 1'b0;
          if (HOLD > 0) begin
            cnt_load  = 1'b1;
            cnt_val   = CW'(HOLD - 1);
            state_nxt = S_HOLD;
          end else begin
            done_nxt  = 1'b1;
            if (bus.Q == d_q) err_nxt = 1'b0;
            else              err_nxt = 1'b1;
            state_nxt = S_IDLE;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_HOLD: begin
        e_nxt = 1'b0;
        if (cnt_zero_c) begin
          done_nxt  = 1'b1;
          if (bus.Q == d_q) err_nxt = 1'b0;
          else              err_nxt = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        e_nxt     = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      d_q    <= '0;
      e_q    <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      d_q    <= d_nxt;
      e_q    <= e_nxt;
      done_q <= done_nxt;
      err_q  <= err_nxt;
    end
  end

  assign bus.rdy  = (state == S_IDLE);
  assign bus.D    = d_q;
  assign bus.E    = e_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;

endmodule
